// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin arbiter that locks a grant to one owner until it signals release
module stream_rr_arbiter #(
    parameter int N  = 4,
    parameter int LN = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_in,
    input  logic          release_in,
    output logic [N-1:0]  grant_out,
    output logic [LN-1:0] grant_index_out,
    output logic          grant_valid_out
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t        r_state;
    logic [LN-1:0] r_ptr;
    logic [N-1:0]  r_grant;
    logic [LN-1:0] r_index;
    logic          r_valid;
    logic [LN-1:0] w_lo_idx;
    logic [LN-1:0] w_hi_idx;
    logic          w_hi_any;
    logic [LN-1:0] w_win;
    // Lowest requester overall and lowest requester strictly above the last winner
    always_comb begin
        w_lo_idx = '0;
        w_hi_idx = '0;
        w_hi_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_in[i]) begin
                w_lo_idx = LN'(i);
                if (LN'(i) > r_ptr) begin
                    w_hi_idx = LN'(i);
                    w_hi_any = 1'b1;
                end
            end
        end
    end
    assign w_win = w_hi_any ? w_hi_idx : w_lo_idx;
    // Arbitrate only from IDLE with release low, so a held release can never free a fresh grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= LN'(N - 1);
            r_grant <= '0;
            r_index <= '0;
            r_valid <= 1'b0;
        end else if (r_state == IDLE) begin
            if (|req_in && !release_in) begin
                r_state <= BUSY;
                r_ptr   <= w_win;
                r_grant <= N'(1) << w_win;
                r_index <= w_win;
                r_valid <= 1'b1;
            end
        end else if (release_in) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_index <= '0;
            r_valid <= 1'b0;
        end
    end
    assign grant_out       = r_grant;
    assign grant_index_out = r_index;
    assign grant_valid_out = r_valid;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: table vectors, corner sequences and randomized model check for N=4 and N=5
module tb_stream_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req4 = '0;
    logic       rel4 = 1'b0;
    logic [3:0] g4;
    logic [1:0] g4i;
    logic       g4v;
    logic [4:0] req5 = '0;
    logic       rel5 = 1'b0;
    logic [4:0] g5;
    logic [2:0] g5i;
    logic       g5v;
    int vectors = 0;
    int misc = 0;
    int own4 = -1, p4 = 3, own5 = -1, p5 = 4;

    typedef struct {
        logic [3:0] req;
        logic       rel;
        logic [3:0] grant;
        logic [1:0] idx;
        logic       valid;
    } vec_t;
    vec_t tbl[$];

    stream_rr_arbiter #(.N(4)) dut4 (
        .clk(clk), .rst(rst), .req_in(req4), .release_in(rel4),
        .grant_out(g4), .grant_index_out(g4i), .grant_valid_out(g4v)
    );
    stream_rr_arbiter #(.N(5)) dut5 (
        .clk(clk), .rst(rst), .req_in(req5), .release_in(rel5),
        .grant_out(g5), .grant_index_out(g5i), .grant_valid_out(g5v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misc++;
            $display("FAIL %s: got 0x%0h, need 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: idle + request + no release picks the first requester after p circularly; busy + release frees
    task automatic mdl(input int n, input logic [31:0] req, input logic rel,
                       input int own_i, input int p_i, output int own_o, output int p_o);
        own_o = own_i;
        p_o = p_i;
        if (own_i < 0) begin
            if (req != 0 && !rel)
                for (int k = 1; k <= n; k++) begin
                    int j;
                    j = (p_i + k) % n;
                    if (req[j]) begin
                        own_o = j;
                        p_o = j;
                        break;
                    end
                end
        end else if (rel) own_o = -1;
    endtask

    task automatic step();
        int o, p;
        @(posedge clk);
        mdl(4, 32'(req4), rel4, own4, p4, o, p);
        own4 = o; p4 = p;
        mdl(5, 32'(req5), rel5, own5, p5, o, p);
        own5 = o; p5 = p;
        #1;
    endtask

    task automatic model_reset();
        own4 = -1; p4 = 3; own5 = -1; p5 = 4;
    endtask

    task automatic chk_models(input string tag);
        chk({tag, "_v4"}, 32'(g4v), 32'(own4 >= 0));
        chk({tag, "_i4"}, 32'(g4i), own4 >= 0 ? 32'(own4) : 32'd0);
        chk({tag, "_g4"}, 32'(g4), own4 >= 0 ? 32'd1 << own4 : 32'd0);
        chk({tag, "_v5"}, 32'(g5v), 32'(own5 >= 0));
        chk({tag, "_i5"}, 32'(g5i), own5 >= 0 ? 32'(own5) : 32'd0);
        chk({tag, "_g5"}, 32'(g5), own5 >= 0 ? 32'd1 << own5 : 32'd0);
    endtask

    task automatic chk4(input string nm, input logic [3:0] g, input logic [1:0] i, input logic v);
        chk({nm, "_grant"}, 32'(g4), 32'(g));
        chk({nm, "_idx"}, 32'(g4i), 32'(i));
        chk({nm, "_valid"}, 32'(g4v), 32'(v));
    endtask

    initial begin
        // all-request rotation with single-cycle releases
        tbl.push_back('{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1});
        tbl.push_back('{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1});
        tbl.push_back('{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1});
        tbl.push_back('{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1});
        tbl.push_back('{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1});
        tbl.push_back('{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0});
        // single requester, then request dropped while locked
        tbl.push_back('{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1});
        tbl.push_back('{4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1});
        tbl.push_back('{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0});
        // owner 1, then 3 above it, then wrap to 0
        tbl.push_back('{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1});
        tbl.push_back('{4'b1001, 1'b1, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1});
        tbl.push_back('{4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b1});
        // release held three cycles: one release, no re-grant until it drops
        tbl.push_back('{4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1});
        tbl.push_back('{4'b0011, 1'b1, 4'b0000, 2'd0, 1'b0});
        // release in idle leaves the pointer at 1, so 0011 wraps to 0
        tbl.push_back('{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1});
        tbl.push_back('{4'b0110, 1'b0, 4'b0001, 2'd0, 1'b1});
        tbl.push_back('{4'b0110, 1'b1, 4'b0000, 2'd0, 1'b0});
        tbl.push_back('{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1});

        #12;
        chk4("reset", 4'b0000, 2'd0, 1'b0);
        chk("reset_g5", 32'(g5), 32'd0);
        rst = 1'b0;
        foreach (tbl[k]) begin
            req4 = tbl[k].req;
            rel4 = tbl[k].rel;
            step();
            chk4($sformatf("vec%0d", k), tbl[k].grant, tbl[k].idx, tbl[k].valid);
        end

        // asynchronous reset between edges while busy on index 2
        #2 rst = 1'b1;
        model_reset();
        #1 chk4("async_rst", 4'b0000, 2'd0, 1'b0);
        req4 = 4'b1111;
        rel4 = 1'b0;
        #1 rst = 1'b0;
        step();
        chk4("post_rst", 4'b0001, 2'd0, 1'b1);

        // N=5: top requester, then release ignored in idle, then wrap to 0
        req5 = 5'b10000;
        rel5 = 1'b0;
        step();
        chk("n5_grant", 32'(g5), 32'h10);
        chk("n5_idx", 32'(g5i), 32'd4);
        chk("n5_valid", 32'(g5v), 32'd1);
        req5 = 5'b00000;
        rel5 = 1'b1;
        step();
        chk("n5_rel", 32'(g5v), 32'd0);
        step();
        chk("n5_idle_rel_g", 32'(g5), 32'd0);
        chk("n5_idle_rel_i", 32'(g5i), 32'd0);
        req5 = 5'b00001;
        rel5 = 1'b0;
        step();
        chk("n5_wrap_g", 32'(g5), 32'h01);
        chk("n5_wrap_i", 32'(g5i), 32'd0);

        // randomized traffic against the reference model
        for (int c = 0; c < 600; c++) begin
            req4 = 4'($urandom);
            rel4 = ($urandom_range(0, 2) == 0);
            req5 = ($urandom_range(0, 3) == 0) ? 5'($urandom) & 5'b10001 : 5'($urandom);
            rel5 = ($urandom_range(0, 2) == 0);
            if (c == 300) begin
                rst = 1'b1;
                model_reset();
                #1 chk_models("rnd_rst");
                rst = 1'b0;
            end
            step();
            chk_models("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        $finish;
    end
endmodule
